// File: rtl/cordic_feeder.sv
// cordic_feeder: input pacing stage in front of the iterative complex-to-polar
// CORDIC. Buffers complex samples in a small FIFO, issues one-cycle trig
// pulses no closer than CORDIC_CYCLES apart, and flags any CORDIC vld that
// does not arrive exactly CORDIC_CYCLES after its trig.
module cordic_feeder #(
  parameter int DEPTH         = 8,   // FIFO depth, power of two, >= 2
  parameter int CORDIC_CYCLES = 14   // trig spacing and trig-to-vld latency, >= 3
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [8:0]               s_re,
  input  logic [8:0]               s_im,
  input  logic                     flush,
  output logic                     trig,
  output logic [8:0]               re_out,
  output logic [8:0]               im_out,
  input  logic                     cordic_vld,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     seq_err,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CORDIC_CYCLES + 1);

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [CW-1:0] SPACE_LOAD = CW'(CORDIC_CYCLES - 2);
  localparam logic [CW-1:0] EXP_LOAD   = CW'(CORDIC_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Sample storage: {re, im}
  logic [17:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] space_q, space_d;
  logic [CW-1:0] exp_q, exp_d;
  logic          trig_q, trig_d;
  logic [8:0]    re_q, re_d;
  logic [8:0]    im_q, im_d;
  logic          seq_err_q, seq_err_d;

  logic          push;
  logic          pop;
  logic          can_pop;
  logic          err_set;

  assign s_ready = (level_q != FULL_LEVEL) && !flush;
  assign push    = s_valid && s_ready;
  assign can_pop = (level_q != '0) && !flush;

  // Sequencer: decides when to pop the head and fire the next trig.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    space_d = space_q;
    trig_d  = 1'b0;
    re_d    = re_q;
    im_d    = im_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          trig_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        space_d = SPACE_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (space_q != '0) begin
          space_d = space_q - CNT_ONE;
        end else if (can_pop) begin
          pop     = 1'b1;
          trig_d  = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      {re_d, im_d} = mem_q[rd_ptr_q];
    end
  end

  // FIFO bookkeeping; a flush realigns the read pointer to the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end
  end

  // Result checker: exactly one vld in the slot CORDIC_CYCLES after each trig.
  always_comb begin
    exp_d = exp_q;
    if (trig_q) begin
      exp_d = EXP_LOAD;
    end else if (exp_q != '0) begin
      exp_d = exp_q - CNT_ONE;
    end
    err_set   = cordic_vld ^ (exp_q == CNT_ONE);
    seq_err_d = err_set | (seq_err_q & ~clr_err);
  end

  // Sample storage write port.
  always_ff @(posedge sys_clk) begin
    // NOTE: the storage array carries no reset; the pointers and level
    // define which entries are meaningful, so stale contents never leak.
    if (push) begin
      mem_q[wr_ptr_q] <= {s_re, s_im};
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= IDLE;
      space_q   <= '0;
      exp_q     <= '0;
      trig_q    <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
      seq_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      space_q   <= space_d;
      exp_q     <= exp_d;
      trig_q    <= trig_d;
      re_q      <= re_d;
      im_q      <= im_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign trig       = trig_q;
  assign re_out     = re_q;
  assign im_out     = im_q;
  assign busy       = (state_q != IDLE);
  assign fifo_level = level_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_cordic_feeder.sv
// Self-checking bench for cordic_feeder. A queue-based reference model tracks
// the buffered samples and the rule "pops at least CORDIC_CYCLES cycles
// apart"; a behavioural CORDIC responder returns vld after each trig.
module tb_cordic_feeder;

  localparam int DEPTH = 8;
  localparam int CC    = 14;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       s_valid   = 1'b0;
  logic       flush     = 1'b0;
  logic       cordic_vld = 1'b0;
  logic       clr_err   = 1'b0;
  logic [8:0] s_re      = '0;
  logic [8:0] s_im      = '0;
  logic       s_ready;
  logic       trig;
  logic [8:0] re_out;
  logic [8:0] im_out;
  logic       busy;
  logic [3:0] fifo_level;
  logic       seq_err;

  cordic_feeder #(.DEPTH(DEPTH), .CORDIC_CYCLES(CC)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_re       (s_re),
    .s_im       (s_im),
    .flush      (flush),
    .trig       (trig),
    .re_out     (re_out),
    .im_out     (im_out),
    .cordic_vld (cordic_vld),
    .busy       (busy),
    .fifo_level (fifo_level),
    .seq_err    (seq_err),
    .clr_err    (clr_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [8:0] re;
    logic [8:0] im;
  } sample_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  sample_t m_q[$];
  sample_t m_cur;
  bit      m_have_pop;
  int      m_last_pop;
  bit      m_popped;
  bit      m_pushed;
  bit      m_seq_err;
  int      m_slots[$];

  // CORDIC responder state
  int      due[$];
  bit      delay_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur      = '0;
    m_have_pop = 1'b0;
    m_last_pop = 0;
    m_popped   = 1'b0;
    m_pushed   = 1'b0;
    m_seq_err  = 1'b0;
    m_slots.delete();
    due.delete();
    delay_next = 1'b0;
    cordic_vld = 1'b0;
  endtask

  // One clock cycle: predict, clock, compare, then act as the CORDIC.
  task automatic tick();
    bit ready_m, push, pop, can, slot;
    #1;
    ready_m = (m_q.size() != DEPTH) && !flush;
    check("s_ready", s_ready, ready_m);
    push = s_valid && ready_m;
    can  = !m_have_pop || (cyc - m_last_pop >= CC);
    pop  = !flush && (m_q.size() > 0) && can;
    slot = 1'b0;
    foreach (m_slots[i]) if (m_slots[i] == cyc) slot = 1'b1;
    if (cordic_vld != slot) m_seq_err = 1'b1;
    else if (clr_err)       m_seq_err = 1'b0;
    while (m_slots.size() > 0 && m_slots[0] <= cyc) void'(m_slots.pop_front());
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) begin
        m_cur      = m_q.pop_front();
        m_last_pop = cyc;
        m_have_pop = 1'b1;
        m_slots.push_back(cyc + 1 + CC);
      end
      if (push) m_q.push_back({s_re, s_im});
    end
    m_popped = pop;
    m_pushed = push;

    @(posedge sys_clk);
    cyc++;
    #1;
    check("trig",       trig,       m_popped);
    check("re_out",     re_out,     m_cur.re);
    check("im_out",     im_out,     m_cur.im);
    check("busy",       busy,       m_have_pop && ((cyc - 1 - m_last_pop) <= CC - 1));
    check("fifo_level", fifo_level, m_q.size());
    check("seq_err",    seq_err,    m_seq_err);

    if (trig) begin
      due.push_back(cyc + CC + (delay_next ? 1 : 0));
      delay_next = 1'b0;
    end
    cordic_vld = 1'b0;
    if (due.size() > 0 && due[0] == cyc) begin
      cordic_vld = 1'b1;
      void'(due.pop_front());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked before any edge.
  task automatic do_reset();
    s_valid   = 1'b0;
    flush     = 1'b0;
    clr_err   = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_trig",    trig,       0);
    check("rst_busy",    busy,       0);
    check("rst_level",   fifo_level, 0);
    check("rst_seq_err", seq_err,    0);
    check("rst_re",      re_out,     0);
    check("rst_im",      im_out,     0);
    check("rst_s_ready", s_ready,    1);
    @(posedge sys_clk);
    cyc++;
    #1;
    sys_rst_n = 1'b1;
  endtask

  // Offer n random samples, holding each until accepted (bounded).
  task automatic send(input int n);
    int sent = 0;
    int budget = n * CC * 2 + 20;
    s_re    = 9'($urandom);
    s_im    = 9'($urandom);
    s_valid = 1'b1;
    while (sent < n && budget > 0) begin
      tick();
      budget--;
      if (m_pushed) begin
        sent++;
        s_re = 9'($urandom);
        s_im = 9'($urandom);
      end
    end
    s_valid = 1'b0;
    if (sent < n) check("send_timeout", sent, n);
  endtask

  initial begin
    #2;
    do_reset();

    // Single sample into an empty FIFO
    s_re = 9'h040; s_im = 9'h1C0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    ticks(2);
    check("single_re", re_out, 9'h040);
    check("single_im", im_out, 9'h1C0);
    ticks(20);

    // Burst beyond depth: backpressure, full-with-pop, exact spacing
    send(DEPTH + 3);
    ticks(CC * (DEPTH + 4));

    // Late vld: seq_err sets and holds until cleared
    delay_next = 1'b1;
    send(1);
    ticks(40);
    check("late_sticky", seq_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    ticks(5);

    // Flush with 5 samples queued during WAIT
    send(6);
    ticks(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ticks(40);

    // Reset mid-WAIT with 3 samples queued
    send(4);
    ticks(3);
    do_reset();
    ticks(30);

    // Randomised traffic with occasional flush, clear and late vld
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_re    = 9'($urandom);
      s_im    = 9'($urandom);
      flush   = ($urandom_range(0, 63) == 0);
      clr_err = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 9) == 0) delay_next = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    ticks(CC * (DEPTH + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
